// File: rtl/lsu_pkg.sv
// Shared types and width codes for the MEM-stage load/store initiator.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads; a store with BU/HU is illegal.
  function automatic logic lsu_is_legal(input logic store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend and store merge into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    shamt     = {off, 3'b000};
    shifted   = word >> shamt;
    load_data = word;
    lane_mask = '1;
    case (funct3[1:0])
      2'b00: begin
        load_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      2'b01: begin
        load_data = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    merged = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store FSM driving a word-wide memory without byte enables.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete with resp_err.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DAT_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [DAT_WIDTH-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DAT_WIDTH-1:0]  mem_rdata
);

  lsu_state_e           state;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic [DAT_WIDTH-1:0] data_q;

  logic [1:0]           req_off;
  logic                 misaligned;
  logic [DAT_WIDTH-1:0] load_data;
  logic [DAT_WIDTH-1:0] merged;

  always_comb begin
    req_off    = req_addr[1:0];
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: ;
    endcase
`else
    // Without the trap, misaligned halfwords/words silently round down.
    case (req_funct3[1:0])
      2'b01:   req_off[0] = 1'b0;
      2'b10:   req_off    = 2'b00;
      default: ;
    endcase
`endif
  end

  lsu_align u_align (
    .word      (mem_rdata),
    .wdata     (data_q),
    .off       (off_q),
    .funct3    (f3_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
            f3_q       <= req_funct3;
            off_q      <= req_off;
            data_q     <= req_wdata;
            if (!lsu_is_legal(req_store, req_funct3) || misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= ST_RESP;
            end else if (!req_store) begin
              mem_read <= 1'b1;
              state    <= ST_LD;
            end else if (req_funct3 == F3_W) begin
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= ST_WR;
            end else begin
              mem_read <= 1'b1;
              state    <= ST_RMW_RD;
            end
          end
        end
        ST_LD: begin
          mem_read   <= 1'b0;
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_wdata <= merged;
          state     <= ST_RMW_WR;
        end
        ST_WR, ST_RMW_WR: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed table, reset abort, randomized model comparison.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  lsu_mem_master #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT and an independent reference copy.
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  logic        mem_init;
  int          wr_total = 0;
  int          overlap  = 0;
  int          idle_strobe = 0;

  assign mem_rdata = tb_mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= i;
    end else if (mem_write) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_write) wr_total++;
    if (mem_read && mem_write) overlap++;
    if (req_ready && (mem_read || mem_write)) idle_strobe++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed arithmetic over the model memory.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat, output int nrd, output int nwr);
    int size, off, idx;
    longint v;
    logic [31:0] bv;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err  = !((f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5)));
`ifdef LSU_MISALIGN_TRAP_EN
    if (int'(a % 4) % size != 0) err = 1'b1;
`endif
    rd = 32'h0; nrd = 0; nwr = 0;
    if (err) begin
      lat = 1;
      return;
    end
    off = (int'(a % 4) / size) * size;
    idx = int'((a / 4) % 256);
    if (!st) begin
      v = 0;
      for (int b = 0; b < size; b++)
        v = v | (longint'((ref_mem[idx] >> (8 * (off + b))) & 32'hFF) << (8 * b));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      rd = v[31:0];
      lat = 2; nrd = 1;
    end else begin
      for (int b = 0; b < size; b++) begin
        bv = (wd >> (8 * b)) & 32'hFF;
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * (off + b)))) | (bv << (8 * (off + b)));
      end
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  // Issues one request and measures the DUT's response and strobe activity.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int nrd, output int nwr, output logic busy_ok);
    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_store = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
    lat = 1; nrd = 0; nwr = 0; busy_ok = 1'b1;
    while (!resp_valid && lat < 10) begin
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (req_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat);
    end
    if (req_ready) busy_ok = 1'b0;
    err = resp_err;
    rd  = resp_rdata;
    @(negedge clk);
    check("resp_one_cycle", {31'b0, resp_valid}, 32'h0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic        g_err, m_err, busy_ok;
    logic [31:0] g_rd, m_rd;
    int          g_lat, m_lat, g_nrd, m_nrd, g_nwr, m_nwr, w0, mism;
    string       tag;

    vecs[0]  = '{1'b0, 3'b010, 32'h14, 32'h0,        1'b0, 32'h0000_0005, 2, 1, 0};
    vecs[1]  = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0,         2, 0, 1};
    vecs[2]  = '{1'b0, 3'b000, 32'h0B, 32'h0,        1'b0, 32'hFFFF_FFDE, 2, 1, 0};
    vecs[3]  = '{1'b0, 3'b100, 32'h0B, 32'h0,        1'b0, 32'h0000_00DE, 2, 1, 0};
    vecs[4]  = '{1'b0, 3'b001, 32'h0A, 32'h0,        1'b0, 32'hFFFF_DEAD, 2, 1, 0};
    vecs[5]  = '{1'b0, 3'b101, 32'h08, 32'h0,        1'b0, 32'h0000_BEEF, 2, 1, 0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0D, 32'h0000_00AA, 1'b0, 32'h0,        3, 1, 1};
    vecs[7]  = '{1'b0, 3'b010, 32'h0C, 32'h0,        1'b0, 32'h0000_AA03, 2, 1, 0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[8]  = '{1'b0, 3'b010, 32'h06, 32'h0,        1'b1, 32'h0,         1, 0, 0};
`else
    vecs[8]  = '{1'b0, 3'b010, 32'h06, 32'h0,        1'b0, 32'h0000_0001, 2, 1, 0};
`endif
    vecs[9]  = '{1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0,         1, 0, 0};
    vecs[10] = '{1'b1, 3'b100, 32'h10, 32'h55,       1'b1, 32'h0,         1, 0, 0};
    vecs[11] = '{1'b1, 3'b001, 32'h1A, 32'h0000_1234, 1'b0, 32'h0,        3, 1, 1};
    vecs[12] = '{1'b0, 3'b010, 32'h18, 32'h0,        1'b0, 32'h1234_0006, 2, 1, 0};

    for (int i = 0; i < 256; i++) ref_mem[i] = i;
    rst_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  {31'b0, req_ready},  32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata,          32'h0);
    check("rst_resp_err",   {31'b0, resp_err},   32'h0);
    check("rst_mem_addr",   mem_addr,            32'h0);
    check("rst_mem_wdata",  mem_wdata,           32'h0);
    check("rst_mem_write",  {31'b0, mem_write},  32'h0);
    check("rst_mem_read",   {31'b0, mem_read},   32'h0);
    rst_n = 1'b1; mem_init = 1'b0;

    // Directed vectors; the model is stepped alongside so its memory stays in sync.
    for (int i = 0; i < 13; i++) begin
      model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_err, m_rd, m_lat, m_nrd, m_nwr);
      run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, g_err, g_rd, g_lat, g_nrd, g_nwr, busy_ok);
      tag = $sformatf("vec%0d", i);
      check({tag, "_err"},   {31'b0, g_err}, {31'b0, vecs[i].err});
      check({tag, "_rdata"}, g_rd,  vecs[i].rdata);
      check({tag, "_lat"},   g_lat, vecs[i].lat);
      check({tag, "_nrd"},   g_nrd, vecs[i].nrd);
      check({tag, "_nwr"},   g_nwr, vecs[i].nwr);
      check({tag, "_busy"},  {31'b0, busy_ok}, 32'h1);
      if (i == 6) check("sb_word3", tb_mem[3], 32'h0000_AA03);
    end

    // SB to word 4 aborted by reset during RMW_RD.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_rmw_rd", {31'b0, mem_read}, 32'h1);
    w0 = wr_total;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_write",   wr_total - w0,       32'h0);
    check("abort_word4",      tb_mem[4],           32'h4);
    check("abort_ready",      {31'b0, req_ready},  32'h1);
    check("abort_no_resp",    {31'b0, resp_valid}, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      st = $urandom_range(0, 1);
      f3 = $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      wd = $urandom;
      model(st, f3, a, wd, m_err, m_rd, m_lat, m_nrd, m_nwr);
      run_req(st, f3, a, wd, g_err, g_rd, g_lat, g_nrd, g_nwr, busy_ok);
      check("rnd_err",   {31'b0, g_err}, {31'b0, m_err});
      check("rnd_rdata", g_rd,  m_rd);
      check("rnd_lat",   g_lat, m_lat);
      check("rnd_nrd",   g_nrd, m_nrd);
      check("rnd_nwr",   g_nwr, m_nwr);
      check("rnd_busy",  {31'b0, busy_ok}, 32'h1);
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    check("final_mem_image", mism, 32'h0);
    check("rd_wr_overlap",   overlap, 32'h0);
    check("strobe_in_idle",  idle_strobe, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator sitting in the MEM stage between the pipeline and the word-wide data memory. Accepts one load or store request at a time from EX/MEM and translates RV32I byte/halfword/word accesses into word-indexed memory cycles. Sub-word stores use read-modify-write because the memory has no byte enables. Returns sign/zero-extended load data with a one-cycle response pulse, and stalls the pipeline through `req_ready`.

## Interface
- `ADDR_WIDTH`, 32, byte-address width from pipeline and memory address width
- `DAT_WIDTH`, 32, data width; fixed at 32, other values unsupported
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; transfer when `req_valid && req_ready`
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  DAT_WIDTH  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure
- `resp_rdata`  out  DAT_WIDTH  extended load data; 0 for stores and errors
- `resp_err`  out  1  valid with `resp_valid`; access not performed
- `mem_addr`  out  ADDR_WIDTH  word index = `{2'b0, addr[31:2]}`
- `mem_wdata`  out  DAT_WIDTH  write word
- `mem_write`  out  1  synchronous write strobe
- `mem_read`  out  1  read enable; memory returns `mem_rdata` combinationally
- `mem_rdata`  in  DAT_WIDTH  read word

## Operation
- States: IDLE, LD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: on handshake, latch store flag, funct3, word index, byte offset `addr[1:0]`, and store data. Then go to:
  - LD for loads;
  - WR for SW;
  - RMW_RD for SB/SH;
  - RESP with err=1 for funct3 011/110/111, for stores with funct3 100/101, or for a misaligned access when the macro is enabled.
- LD: `mem_read`=1. Select byte/half at the offset, extend (B/H signed, BU/HU zero), register it into `resp_rdata`, go to RESP.
- WR: `mem_write`=1 with `mem_wdata` = latched data, go to RESP.
- RMW_RD: `mem_read`=1. Merge the store byte/half into `mem_rdata` at the offset, register the result as the write word, go to RMW_WR.
- RMW_WR: `mem_write`=1 with the merged word, go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- `mem_read` and `mem_write` are never high together, and never high in IDLE or RESP.
- Outside WR/RMW_WR, `mem_wdata` holds its last value; the memory ignores it.

## Timing
- Handshake edge = cycle 0.
- Latency to `resp_valid`: LW/LB/LH/LBU/LHU 2 cycles, SW 2, SB/SH 3, error 1.
- Throughput: one access per latency+1 cycles; `req_ready` is low from cycle 1 through RESP inclusive.
- A store's write commits on the edge leaving WR or RMW_WR, before `resp_valid`.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_addr`=0, `mem_wdata`=0, `mem_write`=0, `mem_read`=0, state IDLE.
- Reset mid-operation: abort immediately. No write is issued if reset is asserted before the RMW_WR/WR edge, and no response is produced.
- Request inputs are don't-care while `req_ready`=0.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, completes with `resp_err`=1 after 1 cycle. No memory strobe is issued.
- Undefined: offset low bits are forced to alignment (H clears bit0, W clears bits1:0) and the access proceeds normally. `resp_err` is asserted only for illegal funct3.

## Structure
- `lsu_pkg`: `lsu_state_e` enum, `funct3` localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), and `lsu_is_legal()` function.
- Sub-module `lsu_align`: purely combinational. Performs load extract/extend and store byte-lane merge from word, offset, and funct3. The FSM lives in `lsu_mem_master`.

## Test plan
- After reset, memory word i = i. LW addr 0x14 → `mem_read` in cycle 1, `mem_addr`=5, `resp_valid` at cycle 2 with `resp_rdata`=0x00000005.
- SW 0xDEADBEEF to 0x08; then:
  - LB 0x0B → 0xFFFFFFDE
  - LBU 0x0B → 0x000000DE
  - LH 0x0A → 0xFFFFDEAD
  - LHU 0x08 → 0x0000BEEF
- SB 0x000000AA to 0x0D (word 3 = 3) → RMW_RD then RMW_WR. Memory word 3 = 0x0000AA03, `resp_valid` at cycle 3, `req_ready` low cycles 1–3.
- LW 0x06:
  - with `LSU_MISALIGN_TRAP_EN` → `resp_err`=1 at cycle 1, `mem_read` never high;
  - without → reads word 1, `resp_rdata`=0x00000001.
- funct3=011 load → `resp_err`=1, `resp_rdata`=0, no memory strobe. SB to 0x10, with `rst_n` pulsed low during RMW_RD → `mem_write` never asserts, word 4 stays 4, `req_ready`=1 after release.
